ff_scan_reader: RTL and testbench

Parallel-capture, serial-readout engine for a bank of `FF` whitebox cells: on request it samples the bank's `Q` outputs in one clock and streams them out one bit per accepted handshake. It is the read side of the flip-flop model, used in the v2x tests as a sequential whitebox with `SETUP`/`CLK_TO_Q` annotated ports and no combinational input-to-output paths. It feeds any serial consumer with a valid/ready handshake.

---
 rtl/ff_scan_pkg.sv | 23 ++
 rtl/ff_scan_reader_if.sv | 29 ++
 rtl/ff_scan_shreg.sv | 41 ++++
 rtl/ff_scan_reader.sv | 104 ++++++++++
 tb/tb_ff_scan_reader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ff_scan_pkg.sv
// Shared types and constants for the flip-flop bank scan reader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ff_scan_pkg;

    // Readout sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Legal range for the captured word width.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Bits needed by the down-counter that indexes the remaining bits.
    // It loads WIDTH-1 and exits at 0, so $clog2(WIDTH) bits always suffice.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/ff_scan_reader_if.sv
// Capture request, parallel word and serial valid/ready stream of the scan reader.
// Latency: n/a (wiring only).
// Backpressure: SR from the consumer holds the stream; SV/SO are held while SR is low.
//
// Signals: E capture request, D parallel word, SR serial ready (towards reader);
//          SO serial bit, SV serial valid, BUSY, DONE (from reader).
interface ff_scan_reader_if #(
    parameter int WIDTH = 8
);
    logic             E;
    logic [WIDTH-1:0] D;
    logic             SR;
    logic             SO;
    logic             SV;
    logic             BUSY;
    logic             DONE;

    // master: drives requests/data and consumes the stream.
    modport master (
        output E, D, SR,
        input  SO, SV, BUSY, DONE
    );

    // slave: the scan reader itself.
    modport slave (
        input  E, D, SR,
        output SO, SV, BUSY, DONE
    );
endinterface

// File: rtl/ff_scan_shreg.sv
// Parallel-load shift register; head bit is the next bit to stream, vacated end fills with 0.
// Latency: load or shift takes effect at the clock edge; head is a register output.
// Backpressure: shift is only applied when the caller asserts it, otherwise contents hold.
//
// Ports: clk, rst (async active-high), load/din parallel load, shift advance, head current bit.
module ff_scan_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             head
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] shifted;

    // Direction is fixed at elaboration: the head sits at bit WIDTH-1 or bit 0,
    // and the register always moves toward the head.
    if (MSB_FIRST) begin : g_msb
        assign shifted = {q[WIDTH-2:0], 1'b0};
        assign head    = q[WIDTH-1];
    end else begin : g_lsb
        assign shifted = {1'b0, q[WIDTH-1:1]};
        assign head    = q[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/ff_scan_reader.sv
// Samples a WIDTH-bit flip-flop bank on E and streams it out one bit per SV&&SR handshake.
// Latency: E at edge k -> first bit valid after edge k; DONE pulses after edge k+WIDTH with SR held high.
// Backpressure: SR low holds SO, SV and the bit counter; each stalled cycle adds one cycle.
//
// Ports: clk, R (async active-high reset), bus (slave modport: E, D, SR in; SO, SV, BUSY, DONE out).
module ff_scan_reader
    import ff_scan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             R,
    ff_scan_reader_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("ff_scan_reader: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            load;
    logic            shift;
    logic            sv_q;
    logic            busy_q;
    logic            done_q;
    logic            head;

    // Next-state, counter and datapath controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.E) begin
                    load    = 1'b1;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // SV is high throughout SHIFT, so SR alone completes the handshake.
                if (bus.SR) begin
                    shift = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state and registered so that
    // they change only at clock edges and carry no input-to-output path.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sv_q    <= (state_d == ST_SHIFT);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    ff_scan_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst   (R),
        .load  (load),
        .shift (shift),
        .din   (bus.D),
        .head  (head)
    );

    // After a full word the register has shifted to all zeros, so SO idles at 0.
    assign bus.SO   = head;
    assign bus.SV   = sv_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_ff_scan_reader.sv
// Directed bench for ff_scan_reader: MSB-first and LSB-first instances sharing clk and R.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: SR patterns applied per cycle from a bit mask.
module tb_ff_scan_reader;

    logic clk;
    logic R;
    int   checks;
    int   errors;

    ff_scan_reader_if #(.WIDTH(8)) bm ();
    ff_scan_reader_if #(.WIDTH(8)) bl ();

    ff_scan_reader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .R   (R),
        .bus (bm)
    );

    ff_scan_reader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .R   (R),
        .bus (bl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic f_so(input bit lsb);
        return lsb ? bl.SO : bm.SO;
    endfunction
    function automatic logic f_sv(input bit lsb);
        return lsb ? bl.SV : bm.SV;
    endfunction
    function automatic logic f_busy(input bit lsb);
        return lsb ? bl.BUSY : bm.BUSY;
    endfunction
    function automatic logic f_done(input bit lsb);
        return lsb ? bl.DONE : bm.DONE;
    endfunction

    task automatic check_idle(input bit lsb, input string tag);
        check({tag, "_so"},   {31'd0, f_so(lsb)},   32'd0);
        check({tag, "_sv"},   {31'd0, f_sv(lsb)},   32'd0);
        check({tag, "_busy"}, {31'd0, f_busy(lsb)}, 32'd0);
        check({tag, "_done"}, {31'd0, f_done(lsb)}, 32'd0);
    endtask

    // Pulse E for one edge with word d; returns at the falling edge after capture.
    task automatic capture(input bit lsb, input logic [7:0] d, input logic first_so, input string tag);
        if (lsb) begin
            bl.E = 1'b1;
            bl.D = d;
        end else begin
            bm.E = 1'b1;
            bm.D = d;
        end
        @(negedge clk);
        bl.E = 1'b0;
        bm.E = 1'b0;
        check({tag, "_sv"},   {31'd0, f_sv(lsb)},   32'd1);
        check({tag, "_busy"}, {31'd0, f_busy(lsb)}, 32'd1);
        check({tag, "_so0"},  {31'd0, f_so(lsb)},   {31'd0, first_so});
    endtask

    // Consume the stream with SR = srpat[i] in cycle i; returns at the falling edge where DONE is seen.
    // done_at is the cycle index of DONE (-1 on timeout); bad counts SV drops and SO changes while stalled.
    task automatic drain(input bit lsb, input logic [31:0] srpat, input bit keep_e,
                         output logic [7:0] word, output int done_at, output int bad);
        logic prev_so;
        logic so;
        logic sr;
        bit   prev_sr;
        word    = 8'h00;
        done_at = -1;
        bad     = 0;
        prev_sr = 1'b1;
        prev_so = 1'b0;
        for (int i = 0; i < 40; i++) begin
            so = f_so(lsb);
            if (f_done(lsb) === 1'b1) begin
                done_at = i;
                break;
            end
            if (f_sv(lsb) !== 1'b1) bad++;
            if (!prev_sr && so !== prev_so) bad++;
            sr = (i < 32) ? srpat[i] : 1'b1;
            bm.SR = sr;
            bl.SR = sr;
            if (keep_e) begin
                if (lsb) begin
                    bl.E = 1'b1;
                    bl.D = 8'($urandom);
                end else begin
                    bm.E = 1'b1;
                    bm.D = 8'($urandom);
                end
            end
            if (sr) word = lsb ? {so, word[7:1]} : {word[6:0], so};
            prev_so = so;
            prev_sr = sr;
            @(negedge clk);
        end
        bm.SR = 1'b1;
        bl.SR = 1'b1;
    endtask

    // At the DONE cycle: one-cycle pulse with BUSY still high, then back to idle.
    task automatic finish_word(input bit lsb, input string tag);
        check({tag, "_done_hi"}, {31'd0, f_done(lsb)}, 32'd1);
        check({tag, "_busy_hi"}, {31'd0, f_busy(lsb)}, 32'd1);
        check({tag, "_sv_lo"},   {31'd0, f_sv(lsb)},   32'd0);
        @(negedge clk);
        check({tag, "_done_lo"}, {31'd0, f_done(lsb)}, 32'd0);
        check({tag, "_busy_lo"}, {31'd0, f_busy(lsb)}, 32'd0);
    endtask

    logic [7:0] word;
    int         done_at;
    int         bad;

    initial begin
        checks = 0;
        errors = 0;
        R     = 1'b1;
        bm.E  = 1'b0;
        bm.D  = 8'h00;
        bm.SR = 1'b1;
        bl.E  = 1'b0;
        bl.D  = 8'h00;
        bl.SR = 1'b1;

        // Reset state, and E ignored while R is held across an edge.
        @(negedge clk);
        check_idle(1'b0, "rst_m");
        check_idle(1'b1, "rst_l");
        bm.E = 1'b1;
        bm.D = 8'hFF;
        @(negedge clk);
        check_idle(1'b0, "rst_prio");
        R    = 1'b0;
        bm.E = 1'b0;
        @(negedge clk);

        // MSB first, 0xA5, SR always high.
        capture(1'b0, 8'hA5, 1'b1, "a5_cap");
        drain(1'b0, 32'hFFFF_FFFF, 1'b0, word, done_at, bad);
        check("a5_word", {24'd0, word}, 32'h0000_00A5);
        check("a5_done_at", done_at, 32'd8);
        check("a5_stream", bad, 32'd0);
        finish_word(1'b0, "a5");

        // LSB first, 0x01: first bit 1, then seven zeros.
        capture(1'b1, 8'h01, 1'b1, "01_cap");
        drain(1'b1, 32'hFFFF_FFFF, 1'b0, word, done_at, bad);
        check("01_word", {24'd0, word}, 32'h0000_0001);
        check("01_done_at", done_at, 32'd8);
        check("01_stream", bad, 32'd0);
        finish_word(1'b1, "01");

        // Backpressure with SR = 1,0,0,1 repeating: eight stalls before the last accept.
        capture(1'b0, 8'hC3, 1'b1, "c3_cap");
        drain(1'b0, 32'h9999_9999, 1'b0, word, done_at, bad);
        check("c3_word", {24'd0, word}, 32'h0000_00C3);
        check("c3_done_at", done_at, 32'd16);
        check("c3_stream", bad, 32'd0);
        finish_word(1'b0, "c3");

        // E held high and D churning during SHIFT; next capture only once back in IDLE.
        capture(1'b0, 8'h96, 1'b1, "eh_cap");
        drain(1'b0, 32'hFFFF_FFFF, 1'b1, word, done_at, bad);
        check("eh_word", {24'd0, word}, 32'h0000_0096);
        check("eh_done_at", done_at, 32'd8);
        check("eh_stream", bad, 32'd0);
        bm.D = 8'h5A;
        finish_word(1'b0, "eh");
        check("eh_idle_sv", {31'd0, bm.SV}, 32'd0);
        @(negedge clk);
        bm.E = 1'b0;
        check("eh_recap_sv", {31'd0, bm.SV}, 32'd1);
        check("eh_recap_so", {31'd0, bm.SO}, 32'd0);
        drain(1'b0, 32'hFFFF_FFFF, 1'b0, word, done_at, bad);
        check("eh_recap_word", {24'd0, word}, 32'h0000_005A);
        check("eh_recap_done_at", done_at, 32'd8);
        finish_word(1'b0, "eh2");

        // Reset mid-word after 3 of 8 bits, then a clean 0x3C word.
        capture(1'b0, 8'hFF, 1'b1, "ab_cap");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 R = 1'b1;
        #1 check_idle(1'b0, "ab_rst");
        @(negedge clk);
        check_idle(1'b0, "ab_hold");
        R = 1'b0;
        @(negedge clk);
        check_idle(1'b0, "ab_nodone1");
        @(negedge clk);
        check_idle(1'b0, "ab_nodone2");
        capture(1'b0, 8'h3C, 1'b0, "3c_cap");
        drain(1'b0, 32'hFFFF_FFFF, 1'b0, word, done_at, bad);
        check("3c_word", {24'd0, word}, 32'h0000_003C);
        check("3c_done_at", done_at, 32'd8);
        check("3c_stream", bad, 32'd0);
        finish_word(1'b0, "3c");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
